// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential radix-2 restoring divider.
// Helpers operate on MaxWidth-bit vectors; callers extend and truncate to their own width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  localparam int unsigned MaxWidth = 64;

  // Two's-complement negate when neg is set. Truncating the result to any width <= MaxWidth
  // yields the negation at that width, so this also serves as abs() given the sign bit.
  function automatic logic [MaxWidth-1:0] neg_if(input logic [MaxWidth-1:0] v, input logic neg);
    return neg ? (~v + MaxWidth'(1)) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // The partial remainder is always below the divisor, so a kept difference fits WIDTH bits.
  always_comb begin
    shifted  = {rem, bit_in};
    q_bit    = (shifted >= {1'b0, divisor});
    rem_next = q_bit ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit_param.sv
// Multi-cycle signed/unsigned integer divider with RISC-V M-extension result semantics.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips CALC/FIX and completes in one cycle.
module div_unit_param
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             sign_i,
  input  logic             div_or_rem_sel_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic [WIDTH-1:0] QR_o,
  output logic             ready_o,
  output logic             busy_o,
  output logic             dbz_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t      state_q;
  logic [CntW-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_q;  // dividend shifts out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            sel_q;
  logic            dbz_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic            a_neg;
  logic            b_neg;
  logic [WIDTH-1:0] rem_next;
  logic            q_bit;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;

  always_comb begin
    a_neg = sign_i & A_i[WIDTH-1];
    b_neg = sign_i & B_i[WIDTH-1];
    a_mag = WIDTH'(neg_if(MaxWidth'(A_i), a_neg));
    b_mag = WIDTH'(neg_if(MaxWidth'(B_i), b_neg));
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_q),
    .bit_in  (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_next(rem_next),
    .q_bit   (q_bit)
  );

  // A zero divisor leaves |A| in the remainder; restoring the dividend sign gives A back.
  always_comb begin
    q_res = dbz_q ? '1 : WIDTH'(neg_if(MaxWidth'(dvd_q), neg_quo_q));
    r_res = WIDTH'(neg_if(MaxWidth'(rem_q), neg_rem_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      sel_q       <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_o  <= '0;
      remainder_o <= '0;
      QR_o        <= '0;
      ready_o     <= 1'b0;
      busy_o      <= 1'b0;
      dbz_o       <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            sel_q     <= div_or_rem_sel_i;
            dbz_q     <= (B_i == '0);
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dvd_q     <= a_mag;
            dvs_q     <= b_mag;
            rem_q     <= '0;
            cnt_q     <= CntW'(WIDTH - 1);
            busy_o    <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
            if (B_i == '0) begin
              quotient_o  <= '1;
              remainder_o <= A_i;
              QR_o        <= div_or_rem_sel_i ? A_i : '1;
              dbz_o       <= 1'b1;
              ready_o     <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= CALC;
            end
`else
            state_q <= CALC;
`endif
          end
        end
        CALC: begin
          rem_q <= rem_next;
          dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quotient_o  <= q_res;
          remainder_o <= r_res;
          QR_o        <= sel_q ? r_res : q_res;
          dbz_o       <= dbz_q;
          ready_o     <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_o  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/div_unit_param.md
# div_unit_param

Parametrised sequential radix-2 restoring divider: the next-generation integer divide unit of the datapath. It accepts a start pulse with two WIDTH-bit operands, runs one quotient bit per cycle, and returns quotient and remainder together, plus a selected result. Signed and unsigned modes follow RISC-V M-extension semantics, including divide-by-zero and overflow. It serves the classifier's fixed-point normalisation logic and any other client that needs a multi-cycle divide.

## Interface
- WIDTH, 32, operand/result width in bits; legal range ≥ 2.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  request pulse; accepted only in IDLE.
- A_i  in  WIDTH  dividend; sampled on the accepting edge only.
- B_i  in  WIDTH  divisor; sampled on the accepting edge only.
- sign_i  in  1  1 = signed (two's complement), 0 = unsigned; latched on accept.
- div_or_rem_sel_i  in  1  0 = QR_o carries the quotient, 1 = QR_o carries the remainder; latched on accept.
- quotient_o  out  WIDTH  final quotient; held until the next accept.
- remainder_o  out  WIDTH  final remainder; held until the next accept.
- QR_o  out  WIDTH  quotient_o or remainder_o, chosen by the latched select.
- ready_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high whenever state ≠ IDLE.
- dbz_o  out  1  divisor was zero; valid with ready_o, held with the results.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start_i = 1, latch sign/select.
  - Load magnitudes |A| and |B| (when sign_i = 1; raw operands otherwise).
  - Record neg_q = sign(A) XOR sign(B) and neg_r = sign(A).
  - Clear the partial remainder, set the counter to WIDTH-1, go to CALC.
- CALC:
  - Each cycle: shift {rem, dividend} left by 1.
  - Trial-subtract |B|; if there is no borrow, keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - When the counter reaches 0, go to FIX.
- FIX:
  - Negate the quotient if neg_q; negate the remainder if neg_r.
  - Register quotient_o, remainder_o, QR_o and dbz_o; go to DONE.
- DONE: ready_o = 1 for this cycle only; then go to IDLE.
- Arithmetic: unsigned magnitudes throughout. |MIN| = 2^(WIDTH-1) as an unsigned value, so no extra bit is needed.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0. This falls out of the datapath and needs no special case.
- Divide by zero, both modes: quotient = all ones, remainder = A_i as given, dbz_o = 1.
- start_i while busy_o = 1, including the DONE cycle: ignored, with no side effects.
- Reset at any time, including mid-operation:
  - Next state IDLE, with no ready_o pulse.
  - All outputs return to their reset values.
- Reset values: quotient_o = 0, remainder_o = 0, QR_o = 0, ready_o = 0, busy_o = 0, dbz_o = 0.

## Timing
- Cycle 0 is the cycle in which start_i is sampled high in IDLE.
- CALC occupies cycles 1..WIDTH; FIX is cycle WIDTH+1; ready_o is high in cycle WIDTH+2.
  - WIDTH = 32 → 34 cycles.
- Earliest next accept: cycle WIDTH+3.
- busy_o is high in cycles 1..WIDTH+2.
- Results change only on the FIX edge or on reset. They are stable from the ready_o cycle until the FIX edge of the next operation.
- Counter width: $clog2(WIDTH).

## Configuration
- DIV_ZERO_FAST_EN defined:
  - If B_i = 0 on accept, IDLE goes directly to DONE.
  - Results and dbz_o are registered on the accepting edge.
  - ready_o is high in cycle 1.
- DIV_ZERO_FAST_EN undefined:
  - A zero divisor runs the full CALC/FIX sequence (ready_o in cycle WIDTH+2).
  - FIX forces the same divide-by-zero results and dbz_o = 1.
- Result values are identical in both builds; only the latency differs.

## Structure
- Package div_pkg holds:
  - the FSM state enum (div_state_t: IDLE, CALC, FIX, DONE);
  - a WIDTH-generic two's-complement negate/abs helper function.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: partial remainder, incoming dividend bit, divisor magnitude.
  - Outputs: next remainder and quotient bit.
  - Instanced once, inside CALC.

## Test plan
- Unsigned 729 / 7, sel = 0 then sel = 1 → QR_o = 104, then 1; ready_o in cycle 34 (WIDTH = 32); dbz_o = 0.
- Signed 729 / 7 with sign combinations:
  - -729 / 7 → Q = -104, R = -1.
  - -729 / -7 → Q = 104, R = -1.
  - 729 / -7 → Q = -104, R = 1.
- Signed 0x80000000 / 0xFFFFFFFF → Q = 0x80000000, R = 0.
- Unsigned 0xFFFFFFFF / 1 → Q = 0xFFFFFFFF, R = 0.
- 729 / 0, signed and unsigned → Q = 0xFFFFFFFF, R = 729, dbz_o = 1.
  - ready_o in cycle 1 with DIV_ZERO_FAST_EN defined, cycle 34 without.
- Busy and reset handling:
  - start_i with 100 / 3 while busy on 729 / 7 → ignored; result stays 104 / 1.
  - reset asserted in cycle 10 → no ready_o, outputs 0, busy_o = 0.
  - A new start after reset completes normally.
- WIDTH = 8 instance: signed -128 / 3 → Q = -42, R = -2; ready_o in cycle 10.
